// File: rtl/pll_reconfig_seq.sv
// Run-time reprogramming sequencer for the 2-output core PLL: writes M/N/C0/C1 through the
// reconfiguration IP's Avalon-MM port, starts reconfiguration, then supervises lock.
module pll_reconfig_seq #(
  parameter int WAIT_TIMEOUT = 1024,
  parameter int LOCK_TIMEOUT = 65536,
  parameter int LOCK_STABLE  = 256
) (
  input  logic        refclk,
  input  logic        rst,
  input  logic        cfg_req,
  input  logic [17:0] cfg_m,
  input  logic [17:0] cfg_n,
  input  logic [17:0] cfg_c0,
  input  logic [17:0] cfg_c1,
  input  logic        pll_locked,
  output logic [5:0]  mgmt_address,
  output logic        mgmt_write,
  output logic [31:0] mgmt_writedata,
  input  logic        mgmt_waitrequest,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code
);

  localparam int WW  = $clog2(WAIT_TIMEOUT + 1);
  localparam int LTW = $clog2(LOCK_TIMEOUT + 1);
  localparam int LSW = $clog2(LOCK_STABLE + 1);

  localparam logic [1:0] CODE_NONE  = 2'd0;
  localparam logic [1:0] CODE_STALL = 2'd1;
  localparam logic [1:0] CODE_LOCK  = 2'd2;

  typedef enum logic [3:0] {
    S_IDLE, S_WR_MODE, S_WR_N, S_WR_M, S_WR_C0, S_WR_C1, S_WR_START,
    S_WAIT_LOCK, S_DONE, S_ERR
  } state_t;

  state_t         state, state_d, wr_next;
  logic [17:0]    m_q, n_q, c0_q, c1_q;
  logic           write_q, write_d;
  logic [5:0]     addr_q, addr_d, wr_addr;
  logic [31:0]    data_q, data_d, wr_data;
  logic [WW-1:0]  stall_q, stall_d;
  logic [LSW-1:0] stable_q, stable_d;
  logic [LTW-1:0] lock_q, lock_d;
  logic           busy_q, busy_d, err_q, err_d;
  logic [1:0]     code_q, code_d;
  logic           sync1, locked_s;

  // Register image for each write state, in the order the reconfig IP expects.
  always_comb begin
    wr_addr = 6'h00;
    wr_data = 32'h0000_0000;
    wr_next = S_IDLE;
    case (state)
      S_WR_MODE:  begin wr_addr = 6'h00; wr_data = 32'h0000_0000;          wr_next = S_WR_N;      end
      S_WR_N:     begin wr_addr = 6'h03; wr_data = {14'b0, n_q};           wr_next = S_WR_M;      end
      S_WR_M:     begin wr_addr = 6'h04; wr_data = {14'b0, m_q};           wr_next = S_WR_C0;     end
      S_WR_C0:    begin wr_addr = 6'h05; wr_data = {9'b0, 5'd0, c0_q};     wr_next = S_WR_C1;     end
      S_WR_C1:    begin wr_addr = 6'h05; wr_data = {9'b0, 5'd1, c1_q};     wr_next = S_WR_START;  end
      S_WR_START: begin wr_addr = 6'h02; wr_data = 32'h0000_0001;          wr_next = S_WAIT_LOCK; end
      default: ;
    endcase
  end

  // NOTE: every variable gets its hold value first so no path through the case infers a latch.
  always_comb begin
    state_d  = state;
    write_d  = write_q;
    addr_d   = addr_q;
    data_d   = data_q;
    stall_d  = stall_q;
    stable_d = stable_q;
    lock_d   = lock_q;
    busy_d   = busy_q;
    err_d    = err_q;
    code_d   = code_q;
    case (state)
      S_IDLE: begin
        if (cfg_req) begin
          state_d = S_WR_MODE;
          busy_d  = 1'b1;
          err_d   = 1'b0;
          code_d  = CODE_NONE;
        end
      end
      S_WR_MODE, S_WR_N, S_WR_M, S_WR_C0, S_WR_C1, S_WR_START: begin
        if (!write_q) begin
          // First cycle in a write state is the idle gap; the strobe goes out next edge.
          write_d = 1'b1;
          addr_d  = wr_addr;
          data_d  = wr_data;
          stall_d = '0;
        end else if (mgmt_waitrequest) begin
          stall_d = stall_q + 1'b1;
          if (stall_d == WW'(WAIT_TIMEOUT)) begin
            write_d = 1'b0;
            state_d = S_ERR;
            code_d  = CODE_STALL;
          end
        end else begin
          write_d = 1'b0;
          state_d = wr_next;
          if (wr_next == S_WAIT_LOCK) begin
            stable_d = '0;
            lock_d   = '0;
          end
        end
      end
      S_WAIT_LOCK: begin
        stable_d = locked_s ? stable_q + 1'b1 : '0;
        lock_d   = lock_q + 1'b1;
        // A stable lock on the final timeout cycle still counts as success.
        if (stable_d == LSW'(LOCK_STABLE)) begin
          state_d = S_DONE;
        end else if (lock_d == LTW'(LOCK_TIMEOUT)) begin
          state_d = S_ERR;
          code_d  = CODE_LOCK;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      S_ERR: begin
        err_d   = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state    <= S_IDLE;
      write_q  <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      stall_q  <= '0;
      stable_q <= '0;
      lock_q   <= '0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      code_q   <= CODE_NONE;
      sync1    <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      state    <= state_d;
      write_q  <= write_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      stall_q  <= stall_d;
      stable_q <= stable_d;
      lock_q   <= lock_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
      code_q   <= code_d;
      sync1    <= pll_locked;
      locked_s <= sync1;
    end
  end

  // NOTE: the held configuration words need no reset; they are always reloaded on acceptance before use.
  always_ff @(posedge refclk) begin
    if (state == S_IDLE && cfg_req) begin
      m_q  <= cfg_m;
      n_q  <= cfg_n;
      c0_q <= cfg_c0;
      c1_q <= cfg_c1;
    end
  end

  assign mgmt_write     = write_q;
  assign mgmt_address   = addr_q;
  assign mgmt_writedata = data_q;
  assign busy           = busy_q;
  assign done           = (state == S_DONE);
  assign err            = err_q;
  assign err_code       = code_q;

endmodule

// File: tb/tb_pll_reconfig_seq.sv
// Self-checking bench for pll_reconfig_seq: a transaction-level reference model predicts every
// output each cycle, randomized configurations and slave stall patterns exercise it.
module tb_pll_reconfig_seq;

  localparam int WT = 16;
  localparam int LT = 100;
  localparam int LS = 4;

  logic        refclk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_req = 1'b0;
  logic [17:0] cfg_m = '0, cfg_n = '0, cfg_c0 = '0, cfg_c1 = '0;
  logic        pll_locked = 1'b0;
  logic [5:0]  mgmt_address;
  logic        mgmt_write;
  logic [31:0] mgmt_writedata;
  logic        mgmt_waitrequest = 1'b0;
  logic        busy, done, err;
  logic [1:0]  err_code;

  pll_reconfig_seq #(.WAIT_TIMEOUT(WT), .LOCK_TIMEOUT(LT), .LOCK_STABLE(LS)) dut (
    .refclk(refclk), .rst(rst), .cfg_req(cfg_req),
    .cfg_m(cfg_m), .cfg_n(cfg_n), .cfg_c0(cfg_c0), .cfg_c1(cfg_c1),
    .pll_locked(pll_locked),
    .mgmt_address(mgmt_address), .mgmt_write(mgmt_write), .mgmt_writedata(mgmt_writedata),
    .mgmt_waitrequest(mgmt_waitrequest),
    .busy(busy), .done(done), .err(err), .err_code(err_code)
  );

  always #10 refclk = ~refclk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Stimulus controls, written only by the main sequence.
  int   slave_k = 0;
  bit   hang_en = 1'b0;
  logic [5:0] hang_addr = '0;
  bit   toggle_en = 1'b0;
  logic lock_level = 1'b1;
  bit   armed = 1'b0;

  // Avalon slave: stalls each write slave_k cycles, or forever on hang_addr.
  int stall_seen = 0;
  initial begin
    int scnt = 0;
    logic prev_wr = 1'b0;
    forever begin
      @(negedge refclk);
      if (mgmt_write && !prev_wr) scnt = 0;
      if (!mgmt_write) mgmt_waitrequest = 1'b0;
      else if (hang_en && mgmt_address == hang_addr) mgmt_waitrequest = 1'b1;
      else if (scnt < slave_k) begin mgmt_waitrequest = 1'b1; scnt++; end
      else mgmt_waitrequest = 1'b0;
      if (mgmt_write && mgmt_waitrequest) stall_seen++;
      prev_wr = mgmt_write;
    end
  end

  // PLL lock source: steady level, or toggling every 3 cycles.
  initial begin
    int   tcnt = 0;
    logic tog = 1'b0;
    forever begin
      @(negedge refclk);
      if (toggle_en) begin
        tcnt++;
        if (tcnt >= 3) begin tcnt = 0; tog = ~tog; end
        pll_locked = tog;
      end else begin
        pll_locked = lock_level;
      end
    end
  end

  // Reference model: a write-list walker. Phase 0 idle, 1 writing list entry widx,
  // 2 waiting for lock, 3 reporting success, 4 reporting error.
  int          ph = 0, widx = 0, stall_n = 0, stab_n = 0, wait_n = 0;
  logic [5:0]  tab_a [6];
  logic [31:0] tab_d [6];
  logic        e_write = 0, e_busy = 0, e_done = 0, e_err = 0;
  logic [5:0]  e_addr = '0;
  logic [31:0] e_data = '0;
  logic [1:0]  e_code = '0;
  logic        ls1 = 0, ls2 = 0, lock_now = 0;
  logic [5:0]  mlog_a [$];
  logic [31:0] mlog_d [$];
  logic [5:0]  dlog_a [$];
  logic [31:0] dlog_d [$];
  int          cyc = 0, start_cyc = 0;

  initial begin
    forever begin
      @(posedge refclk);
      cyc++;
      if (!rst && mgmt_write && !mgmt_waitrequest) begin
        dlog_a.push_back(mgmt_address);
        dlog_d.push_back(mgmt_writedata);
        if (mgmt_address == 6'h02) start_cyc = cyc;
      end
      lock_now = ls2; ls2 = ls1; ls1 = pll_locked;
      if (rst) begin
        ph = 0; e_write = 0; e_addr = '0; e_data = '0; e_busy = 0; e_err = 0; e_code = '0;
        ls1 = 0; ls2 = 0;
      end else begin
        case (ph)
          0: if (cfg_req) begin
            tab_a = '{6'h00, 6'h03, 6'h04, 6'h05, 6'h05, 6'h02};
            tab_d[0] = 32'h0;
            tab_d[1] = 32'(cfg_n);
            tab_d[2] = 32'(cfg_m);
            tab_d[3] = 32'(cfg_c0);
            tab_d[4] = 32'(cfg_c1) + 32'h0004_0000;
            tab_d[5] = 32'h1;
            e_busy = 1; e_err = 0; e_code = 2'd0; widx = 0; ph = 1;
          end
          1: if (!e_write) begin
            e_write = 1; e_addr = tab_a[widx]; e_data = tab_d[widx]; stall_n = 0;
          end else if (mgmt_waitrequest) begin
            stall_n++;
            if (stall_n == WT) begin e_write = 0; e_code = 2'd1; ph = 4; end
          end else begin
            e_write = 0;
            mlog_a.push_back(e_addr);
            mlog_d.push_back(e_data);
            if (widx == 5) begin ph = 2; stab_n = 0; wait_n = 0; end
            else widx++;
          end
          2: begin
            stab_n = lock_now ? stab_n + 1 : 0;
            wait_n++;
            if (stab_n == LS) ph = 3;
            else if (wait_n == LT) begin e_code = 2'd2; ph = 4; end
          end
          3: begin e_busy = 0; ph = 0; end
          default: begin e_err = 1; e_busy = 0; ph = 0; end
        endcase
      end
      e_done = (ph == 3);
    end
  end

  // Per-cycle comparison of every output against the model.
  int   done_cnt = 0, done_cyc = 0, err_cyc = 0;
  initial begin
    logic err_prev = 1'b0;
    forever begin
      @(negedge refclk);
      if (armed) begin
        check("busy",      32'(busy),           32'(e_busy));
        check("done",      32'(done),           32'(e_done));
        check("err",       32'(err),            32'(e_err));
        check("err_code",  32'(err_code),       32'(e_code));
        check("mgmt_write", 32'(mgmt_write),    32'(e_write));
        check("mgmt_address", 32'(mgmt_address), 32'(e_addr));
        check("mgmt_writedata", mgmt_writedata, e_data);
        if (done) begin done_cnt++; done_cyc = cyc; end
        if (err && !err_prev) err_cyc = cyc;
        err_prev = err;
      end
    end
  end

  function automatic logic [31:0] dlog_at(input int i);
    return (i < dlog_d.size()) ? dlog_d[i] : 32'hDEAD_BEEF;
  endfunction
  function automatic logic [31:0] dlog_addr_at(input int i);
    return (i < dlog_a.size()) ? 32'(dlog_a[i]) : 32'hDEAD_BEEF;
  endfunction
  function automatic logic [31:0] mlog_at(input int i);
    return (i < mlog_d.size()) ? mlog_d[i] : 32'hDEAD_BEEF;
  endfunction
  function automatic logic [31:0] mlog_addr_at(input int i);
    return (i < mlog_a.size()) ? 32'(mlog_a[i]) : 32'hDEAD_BEEF;
  endfunction

  task automatic run_req(input logic [17:0] m, n, c0, c1);
    cfg_m = m; cfg_n = n; cfg_c0 = c0; cfg_c1 = c1;
    cfg_req = 1'b1;
    @(negedge refclk);
    cfg_req = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (busy && n < budget) begin @(negedge refclk); n++; end
    check({name, " idle within budget"}, 32'(busy), 32'd0);
  endtask

  task automatic wait_write(input string name, input logic [5:0] a, input int budget);
    int n = 0;
    while (!(mgmt_write && mgmt_address == a) && n < budget) begin @(negedge refclk); n++; end
    check({name, " write seen"}, 32'(mgmt_write && mgmt_address == a), 32'd1);
  endtask

  initial begin
    logic [5:0]  exp_a [6];
    logic [17:0] om, on, oc0, oc1;
    int d0, b0, m0, s0;
    exp_a = '{6'h00, 6'h03, 6'h04, 6'h05, 6'h05, 6'h02};

    repeat (3) @(negedge refclk);
    rst = 1'b0;
    armed = 1'b1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset mgmt_write", 32'(mgmt_write), 32'd0);
    check("reset err_code", 32'(err_code), 32'd0);

    // Zero-wait slave, lock steady high.
    d0 = done_cnt; b0 = dlog_a.size(); m0 = mlog_a.size();
    run_req(18'h00808, 18'($urandom), 18'($urandom), 18'h20302);
    wait_idle("t1", 200);
    check("t1 write count", 32'(dlog_a.size() - b0), 32'd6);
    for (int i = 0; i < 6; i++) begin
      check("t1 dut address order", dlog_addr_at(b0 + i), 32'(exp_a[i]));
      check("t1 model address order", mlog_addr_at(m0 + i), 32'(exp_a[i]));
    end
    check("t1 model m data", mlog_at(m0 + 2), 32'h0000_0808);
    check("t1 model c1 data", mlog_at(m0 + 4), 32'h0006_0302);
    check("t1 dut c1 data", dlog_at(b0 + 4), 32'h0006_0302);
    check("t1 done count", 32'(done_cnt - d0), 32'd1);
    check("t1 done latency", 32'(done_cyc - start_cyc), 32'(LS));
    check("t1 err", 32'(err), 32'd0);

    // Every write stalled 3 cycles.
    slave_k = 3;
    d0 = done_cnt; b0 = dlog_a.size();
    run_req(18'($urandom), 18'($urandom), 18'($urandom), 18'($urandom));
    wait_idle("t2", 300);
    check("t2 write count", 32'(dlog_a.size() - b0), 32'd6);
    check("t2 done count", 32'(done_cnt - d0), 32'd1);

    // Slave hangs on the N write.
    slave_k = 0; hang_en = 1'b1; hang_addr = 6'h03;
    d0 = done_cnt; b0 = dlog_a.size(); s0 = stall_seen;
    run_req(18'($urandom), 18'($urandom), 18'($urandom), 18'($urandom));
    wait_idle("t3", 200);
    hang_en = 1'b0;
    check("t3 err", 32'(err), 32'd1);
    check("t3 err_code", 32'(err_code), 32'd1);
    check("t3 stall cycles", 32'(stall_seen - s0), 32'(WT));
    check("t3 writes completed", 32'(dlog_a.size() - b0), 32'd1);
    check("t3 done count", 32'(done_cnt - d0), 32'd0);

    // Lock never stable long enough, then a clean retry.
    toggle_en = 1'b1;
    d0 = done_cnt;
    run_req(18'($urandom), 18'($urandom), 18'($urandom), 18'($urandom));
    wait_idle("t4", 400);
    check("t4 err_code", 32'(err_code), 32'd2);
    check("t4 lock wait cycles", 32'(err_cyc - start_cyc), 32'(LT + 1));
    check("t4 done count", 32'(done_cnt - d0), 32'd0);
    toggle_en = 1'b0;
    run_req(18'($urandom), 18'($urandom), 18'($urandom), 18'($urandom));
    check("t4 retry err cleared", 32'(err), 32'd0);
    check("t4 retry code cleared", 32'(err_code), 32'd0);
    @(negedge refclk);
    check("t4 retry restarts at mode write", 32'({mgmt_write, mgmt_address}), 32'h40);
    wait_idle("t4 retry", 200);
    check("t4 retry done count", 32'(done_cnt - d0), 32'd1);

    // A request arriving mid-sequence is ignored.
    slave_k = 1;
    om = 18'($urandom); on = 18'($urandom); oc0 = 18'($urandom); oc1 = 18'($urandom);
    b0 = dlog_a.size();
    run_req(om, on, oc0, oc1);
    wait_write("t5 m", 6'h04, 100);
    run_req(~om, ~on, ~oc0, ~oc1);
    wait_idle("t5", 300);
    check("t5 m data", dlog_at(b0 + 2), 32'(om));
    check("t5 c0 data", dlog_at(b0 + 3), 32'(oc0));
    check("t5 c1 data", dlog_at(b0 + 4), 32'(oc1) + 32'h0004_0000);
    check("t5 write count", 32'(dlog_a.size() - b0), 32'd6);

    // Reset in the middle of a stalled C0 write.
    slave_k = 0; hang_en = 1'b1; hang_addr = 6'h05;
    run_req(18'($urandom), 18'($urandom), 18'($urandom), 18'($urandom));
    wait_write("t6 c0", 6'h05, 100);
    repeat (2) @(negedge refclk);
    rst = 1'b1;
    @(negedge refclk);
    rst = 1'b0;
    hang_en = 1'b0;
    check("t6 reset write", 32'(mgmt_write), 32'd0);
    check("t6 reset busy", 32'(busy), 32'd0);
    check("t6 reset data", mgmt_writedata, 32'd0);
    d0 = done_cnt; b0 = dlog_a.size();
    run_req(18'($urandom), 18'($urandom), 18'($urandom), 18'($urandom));
    wait_idle("t6 rerun", 200);
    check("t6 rerun write count", 32'(dlog_a.size() - b0), 32'd6);
    check("t6 rerun done count", 32'(done_cnt - d0), 32'd1);

    // Randomized configurations and stall depths.
    for (int it = 0; it < 8; it++) begin
      slave_k = int'($urandom_range(0, 5));
      d0 = done_cnt; b0 = dlog_a.size();
      run_req(18'($urandom), 18'($urandom), 18'($urandom), 18'($urandom));
      wait_idle("rand", 400);
      check("rand write count", 32'(dlog_a.size() - b0), 32'd6);
      check("rand done count", 32'(done_cnt - d0), 32'd1);
      repeat (int'($urandom_range(0, 3))) @(negedge refclk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
